// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding register,
// so back-to-back words stream out with no idle cycle between them.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             serial_out_q, serial_out_d;
  logic             busy_q, busy_d;
  logic             word_done_q, word_done_d;

  logic             accept;
  logic             load_word;
  logic [WIDTH-1:0] next_word;

  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & ~hold_full_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    serial_out_d = serial_out_q;
    busy_d       = busy_q;
    word_done_d  = 1'b0;
    load_word    = 1'b0;
    next_word    = data_in;

    case (state_q)
      IDLE: begin
        if (accept) load_word = 1'b1;
      end
      default: begin
        if (cnt_q == LAST) begin
          // Word boundary: a held word takes priority; holding full means
          // load_ready is low, so no fresh accept can coincide with it.
          if (hold_full_q) begin
            load_word   = 1'b1;
            next_word   = hold_q;
            hold_full_d = 1'b0;
            hold_d      = '0;
          end else if (accept) begin
            load_word = 1'b1;
          end else begin
            state_d      = IDLE;
            cnt_d        = '0;
            shift_d      = '0;
            serial_out_d = IDLE_BIT;
            busy_d       = 1'b0;
          end
        end else begin
          shift_d      = shift_q << 1;
          serial_out_d = shift_q[WIDTH-2];
          cnt_d        = cnt_q + 1'b1;
          word_done_d  = (cnt_q == PRE_LAST);
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
    endcase

    if (load_word) begin
      state_d      = SHIFT;
      shift_d      = next_word;
      serial_out_d = next_word[WIDTH-1];
      busy_d       = 1'b1;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      serial_out_q <= IDLE_BIT;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: table of single words plus hand-written
// back-to-back, backpressure and mid-word reset sequences.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       serial_out;
  logic       busy;
  logic       word_done;

  int checks   = 0;
  int failures = 0;

  bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .word_done  (word_done)
  );

  always #5 clk = ~clk;

  // Downstream 1101 sequence detector model fed by serial_out.
  logic [3:0] det_hist;
  int         det_hits = 0;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) det_hist <= 4'b0000;
    else begin
      det_hist <= {det_hist[2:0], serial_out};
      if ({det_hist[2:0], serial_out} == 4'b1101) det_hits <= det_hits + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;   // bits[7] is the first bit expected on the line
    int         hits;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s serial_out", tag), 32'(serial_out), 32'd0);
    chk($sformatf("%s busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s word_done", tag), 32'(word_done), 32'd0);
    chk($sformatf("%s load_ready", tag), 32'(load_ready), 32'd1);
  endtask

  task automatic run_word(input logic [7:0] data, input logic [7:0] bits, input int hits,
                          input string tag);
    int h0;
    h0         = det_hits;
    data_in    = data;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = 8'h5A;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("%s c%0d serial_out", tag, c), 32'(serial_out), 32'(bits[8-c]));
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s c%0d word_done", tag, c), 32'(word_done), 32'(c == 8));
      tick();
    end
    chk($sformatf("%s c9 serial_out", tag), 32'(serial_out), 32'd0);
    chk($sformatf("%s c9 busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s c9 word_done", tag), 32'(word_done), 32'd0);
    chk($sformatf("%s detector hits", tag), 32'(det_hits - h0), 32'(hits));
  endtask

  initial begin
    logic [15:0] s16;
    logic [23:0] s24;

    vecs[0] = '{data: 8'hD0, bits: 8'b1101_0000, hits: 1};
    vecs[1] = '{data: 8'h0D, bits: 8'b0000_1101, hits: 1};
    vecs[2] = '{data: 8'hA5, bits: 8'b1010_0101, hits: 0};
    vecs[3] = '{data: 8'h00, bits: 8'b0000_0000, hits: 0};
    vecs[4] = '{data: 8'hFF, bits: 8'b1111_1111, hits: 0};
    vecs[5] = '{data: 8'hB0, bits: 8'b1011_0000, hits: 0};
    vecs[6] = '{data: 8'h01, bits: 8'b0000_0001, hits: 0};

    n_rst      = 1'b0;
    load_valid = 1'b0;
    data_in    = 8'h00;
    tick();
    tick();
    chk_idle("reset");
    n_rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end

    for (int v = 0; v < 7; v++) begin
      run_word(vecs[v].data, vecs[v].bits, vecs[v].hits, $sformatf("vec%0d", v));
      for (int k = 0; k < 4; k++) begin
        tick();
        chk_idle($sformatf("vec%0d gap%0d", v, k));
      end
    end

    // Back-to-back: second word accepted on the edge right after the first.
    s16        = 16'b11010000_00001101;
    data_in    = 8'hD0;
    load_valid = 1'b1;
    tick();
    data_in = 8'h0D;
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) begin
        load_valid = 1'b0;
        data_in    = 8'hEE;
      end
      chk($sformatf("b2b c%0d serial_out", c), 32'(serial_out), 32'(s16[16-c]));
      chk($sformatf("b2b c%0d busy", c), 32'(busy), 32'd1);
      chk($sformatf("b2b c%0d word_done", c), 32'(word_done), 32'(c == 8 || c == 16));
      chk($sformatf("b2b c%0d load_ready", c), 32'(load_ready), 32'(!(c >= 2 && c <= 8)));
      tick();
    end
    chk_idle("b2b c17");

    // Backpressure: load_valid held high across three words.
    s24        = 24'b11010000_10110000_11111111;
    data_in    = 8'hD0;
    load_valid = 1'b1;
    tick();
    data_in = 8'hB0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 2) data_in = 8'hFF;
      if (c == 10) begin
        load_valid = 1'b0;
        data_in    = 8'h33;
      end
      chk($sformatf("bp c%0d serial_out", c), 32'(serial_out), 32'(s24[24-c]));
      chk($sformatf("bp c%0d busy", c), 32'(busy), 32'd1);
      chk($sformatf("bp c%0d word_done", c), 32'(word_done), 32'(c % 8 == 0));
      chk($sformatf("bp c%0d load_ready", c), 32'(load_ready),
          32'(!((c >= 2 && c <= 8) || (c >= 10 && c <= 16))));
      tick();
    end
    chk_idle("bp c25");
    tick();

    // Reset during bit 3 with a word in flight and another held.
    data_in    = 8'hFF;
    load_valid = 1'b1;
    tick();
    data_in = 8'h0D;
    tick();
    load_valid = 1'b0;
    chk("rst pre load_ready", 32'(load_ready), 32'd0);
    tick();
    chk("rst pre busy", 32'(busy), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_idle("rst async");
    #2;
    n_rst = 1'b1;
    chk_idle("rst release");
    run_word(8'hD0, 8'b1101_0000, 1, "post_rst");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle($sformatf("post_rst gap%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
